// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state type, digit geometry and the all-nines saturation pattern.
package bin_to_bcd_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int          BCD_W      = 4;
    localparam logic [3:0]  ADJ_THRESH = 4'd5;
    localparam int          MAX_DIGITS = 16;

    // Pattern of 'digits' BCD nines in the low nibbles; callers slice to their width.
    function automatic logic [4*MAX_DIGITS-1:0] all_nines(input int digits);
        logic [4*MAX_DIGITS-1:0] pat;
        pat = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                pat[i*BCD_W +: BCD_W] = 4'd9;
            end else begin
                pat[i*BCD_W +: BCD_W] = 4'd0;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/bcd_digit_adj3.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional +3 correction for one digit.
    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a start/busy/done handshake and held, saturating result outputs.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int IN_W   = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int ACC_W = BCD_W * (DIGITS + 1);
    localparam int OUT_W = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(IN_W);
    localparam logic [CNT_W-1:0]       LAST_N     = CNT_W'(IN_W - 1);
    localparam logic [4*MAX_DIGITS-1:0] NINES_FULL = all_nines(DIGITS);
    localparam logic [OUT_W-1:0]       NINES      = NINES_FULL[OUT_W-1:0];

    state_t             state_r;
    state_t             state_next_s;
    logic [IN_W-1:0]    sr_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   n_r;

    logic [ACC_W-1:0]   acc_adj_s;
    logic [ACC_W-1:0]   acc_shift_s;
    logic [IN_W-1:0]    sr_shift_s;
    logic               load_s;
    logic               step_s;
    logic               last_s;
    logic               res_ovf_s;
    logic [OUT_W-1:0]   res_bcd_s;

    logic               busy_r;
    logic               done_r;
    logic [OUT_W-1:0]   bcd_r;
    logic               overflow_r;

    // Add-3 correction on every scratch digit, including the overflow digit.
    for (genvar d = 0; d < DIGITS + 1; d++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .din  (acc_r[d*BCD_W +: BCD_W]),
            .dout (acc_adj_s[d*BCD_W +: BCD_W])
        );
    end

    // One shift step of {acc, sr}; the MSB of sr enters acc bit 0.
    always_comb begin
        acc_shift_s = {acc_adj_s[ACC_W-2:0], sr_r[IN_W-1]};
        sr_shift_s  = {sr_r[IN_W-2:0], 1'b0};
    end

    // Result rule: anything in the extra digit (or shifted past it) saturates to nines.
    always_comb begin
        res_ovf_s = acc_adj_s[ACC_W-1] | (|acc_shift_s[ACC_W-1 -: BCD_W]);
        res_bcd_s = acc_shift_s[OUT_W-1:0];
        if (res_ovf_s) begin
            res_bcd_s = NINES;
        end else begin
            res_bcd_s = acc_shift_s[OUT_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and step control.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                step_s = 1'b1;
                if (n_r == LAST_N) begin
                    last_s       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Shift register, scratch accumulator and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r  <= '0;
            acc_r <= '0;
            n_r   <= '0;
        end else if (load_s) begin
            sr_r  <= bin;
            acc_r <= '0;
            n_r   <= '0;
        end else if (step_s) begin
            sr_r  <= sr_shift_s;
            acc_r <= acc_shift_s;
            n_r   <= n_r + CNT_W'(1);
        end else begin
            sr_r  <= sr_r;
            acc_r <= acc_r;
            n_r   <= n_r;
        end
    end

    // Registered handshake and held result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= '0;
            overflow_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == SHIFT);
            done_r <= last_s;
            if (last_s) begin
                bcd_r      <= res_bcd_s;
                overflow_r <= res_ovf_s;
            end else begin
                bcd_r      <= bcd_r;
                overflow_r <= overflow_r;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcd      = bcd_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed handshake cases plus random
// values against a decimal-arithmetic reference, for IN_W=12 and IN_W=14.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start12 = 1'b0;
    logic [11:0] bin12   = 12'd0;
    logic        busy12, done12, ovf12;
    logic [15:0] bcd12;

    logic        start14 = 1'b0;
    logic [13:0] bin14   = 14'd0;
    logic        busy14, done14, ovf14;
    logic [15:0] bcd14;

    int total = 0;
    int bad   = 0;

    always #4 clk = ~clk;

    bin_to_bcd_seq #(.IN_W(12), .DIGITS(4)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .bin(bin12),
        .busy(busy12), .done(done12), .bcd(bcd12), .overflow(ovf12)
    );

    bin_to_bcd_seq #(.IN_W(14), .DIGITS(4)) dut14 (
        .clk(clk), .rst(rst), .start(start14), .bin(bin14),
        .busy(busy14), .done(done14), .bcd(bcd14), .overflow(ovf14)
    );

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int x;
        if (v > 9999) return 16'h9999;
        r = 16'h0000;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full conversion on the selected instance, with latency/result/pulse checks.
    task automatic run(input int w, input int v, input string tag);
        int lat;
        lat = 0;
        if (w == 12) begin bin12 = 12'(v); start12 = 1'b1; end
        else         begin bin14 = 14'(v); start14 = 1'b1; end
        tick();
        start12 = 1'b0;
        start14 = 1'b0;
        check({tag, "_busy"}, 64'(w == 12 ? busy12 : busy14), 64'd1);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if ((w == 12 ? done12 : done14) === 1'b1) begin
                lat = c;
                break;
            end
        end
        check({tag, "_lat"},  64'(lat), 64'(w));
        check({tag, "_bcd"},  64'(w == 12 ? bcd12 : bcd14), 64'(ref_bcd(v)));
        check({tag, "_ovf"},  64'(w == 12 ? ovf12 : ovf14), 64'(v > 9999));
        check({tag, "_nbusy"}, 64'(w == 12 ? busy12 : busy14), 64'd0);
        tick();
        check({tag, "_pulse"}, 64'(w == 12 ? done12 : done14), 64'd0);
    endtask

    initial begin
        int ndone;
        int dlat;
        int idx;
        int v;
        logic [15:0] got;
        int vals[3];

        repeat (3) tick();
        rst = 1'b0;
        check("rst12", 64'({busy12, done12, ovf12, bcd12}), 64'd0);
        check("rst14", 64'({busy14, done14, ovf14, bcd14}), 64'd0);

        run(12, 0,    "zero");
        run(12, 4095, "max12");
        run(12, 1234, "v1234");
        repeat (5) tick();
        check("hold_bcd",  64'(bcd12),  64'h1234);
        check("hold_done", 64'(done12), 64'd0);

        // start during SHIFT (with a different bin) must be ignored
        ndone = 0; dlat = 0; got = 16'h0;
        for (int e = 0; e <= 30; e++) begin
            if (e == 0)      begin start12 = 1'b1; bin12 = 12'd500; end
            else if (e == 5) begin start12 = 1'b1; bin12 = 12'd7;   end
            else             begin start12 = 1'b0; end
            tick();
            if (done12 === 1'b1) begin
                ndone++;
                dlat = e;
                got  = bcd12;
            end
        end
        check("ign_ndone", 64'(ndone), 64'd1);
        check("ign_lat",   64'(dlat),  64'd12);
        check("ign_bcd",   64'(got),   64'h0500);
        check("ign_busy",  64'(busy12), 64'd0);

        // start held high: back-to-back conversions every IN_W+1 cycles
        vals[0] = 9; vals[1] = 10; vals[2] = 99;
        idx = 0;
        bin12 = 12'(vals[0]);
        start12 = 1'b1;
        tick();
        for (int e = 1; e <= 60 && idx < 3; e++) begin
            tick();
            if (done12 === 1'b1) begin
                check("b2b_when", 64'(e), 64'(12 + 13*idx));
                check("b2b_bcd",  64'(bcd12), 64'(ref_bcd(vals[idx])));
                idx++;
                if (idx < 3) bin12 = 12'(vals[idx]);
                else         start12 = 1'b0;
            end
        end
        start12 = 1'b0;
        check("b2b_count", 64'(idx), 64'd3);
        tick();

        // reset mid-conversion aborts with no done pulse
        bin12 = 12'd4095;
        start12 = 1'b1;
        tick();
        start12 = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out", 64'({busy12, done12, ovf12, bcd12}), 64'd0);
        ndone = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (done12 === 1'b1) ndone++;
        end
        check("abort_nodone", 64'(ndone), 64'd0);
        run(12, 4095, "after_abort");

        for (int i = 0; i < 15; i++) begin
            v = int'($urandom_range(0, 4095));
            run(12, v, $sformatf("rnd12_%0d", v));
        end

        run(14, 9999,  "w14_9999");
        run(14, 10000, "w14_10000");
        run(14, 12345, "w14_12345");
        run(14, 16383, "w14_max");
        for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(0, 16383));
            run(14, v, $sformatf("rnd14_%0d", v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
